// File: rtl/iob_cache_axil_bridge.sv
// Bridge from the iob-cache native back-end port to an AXI4-Lite manager.
// One transaction is outstanding at a time. A native request is captured in
// IDLE and then replayed as either an AW+W/B write or an AR/R read.
//
// Ports
//   clk_i, cke_i, arst_i          : clock, clock enable, synchronous active-high reset
//   be_valid_i/be_addr_i/
//   be_wdata_i/be_wstrb_i         : native request (wstrb == 0 selects a read)
//   be_ready_o                    : request accepted (high only in IDLE)
//   be_rdata_o/be_rvalid_o        : read data, held; one-cycle valid pulse
//   axi_aw*/axi_w*/axi_b*         : AXI4-Lite write address, data and response channels
//   axi_ar*/axi_r*                : AXI4-Lite read address and data channels
//   err_o                         : sticky, set by any non-OKAY B or R response
module iob_cache_axil_bridge #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_i,

  input  logic                  be_valid_i,
  input  logic [ADDR_W-1:0]     be_addr_i,
  input  logic [DATA_W-1:0]     be_wdata_i,
  input  logic [DATA_W/8-1:0]   be_wstrb_i,
  output logic                  be_ready_o,
  output logic [DATA_W-1:0]     be_rdata_o,
  output logic                  be_rvalid_o,

  output logic [ADDR_W-1:0]     axi_awaddr_o,
  output logic                  axi_awvalid_o,
  input  logic                  axi_awready_i,

  output logic [DATA_W-1:0]     axi_wdata_o,
  output logic [DATA_W/8-1:0]   axi_wstrb_o,
  output logic                  axi_wvalid_o,
  input  logic                  axi_wready_i,

  input  logic [1:0]            axi_bresp_i,
  input  logic                  axi_bvalid_i,
  output logic                  axi_bready_o,

  output logic [ADDR_W-1:0]     axi_araddr_o,
  output logic                  axi_arvalid_o,
  input  logic                  axi_arready_i,
  input  logic [DATA_W-1:0]     axi_rdata_i,
  input  logic [1:0]            axi_rresp_i,
  input  logic                  axi_rvalid_i,
  output logic                  axi_rready_o,

  output logic                  err_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                err_q;

  logic                accept_c;
  logic                aw_fire_c;
  logic                w_fire_c;
  logic                b_fire_c;
  logic                r_fire_c;

  // Next-state and handshake decode. Handshakes are only acted upon when
  // cke_i is high, which is enforced where they are consumed.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    aw_fire_c = 1'b0;
    w_fire_c  = 1'b0;
    b_fire_c  = 1'b0;
    r_fire_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (be_valid_i) begin
          accept_c = 1'b1;
          state_d  = (|be_wstrb_i) ? WRITE : RADDR;
        end
      end
      WRITE: begin
        // AW and W complete independently; either may finish first.
        aw_fire_c = !aw_done_q && axi_awready_i;
        w_fire_c  = !w_done_q  && axi_wready_i;
        if ((aw_done_q || aw_fire_c) && (w_done_q || w_fire_c)) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        b_fire_c = axi_bvalid_i;
        if (b_fire_c) begin
          state_d = IDLE;
        end
      end
      RADDR: begin
        if (axi_arready_i) begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        r_fire_c = axi_rvalid_i;
        if (r_fire_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request, channel progress, read data and error flag.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // The read-valid pulse lasts one cycle even if cke_i drops after it.
      rvalid_q <= 1'b0;
      if (cke_i) begin
        state_q <= state_d;
        if (accept_c) begin
          addr_q    <= be_addr_i;
          wdata_q   <= be_wdata_i;
          wstrb_q   <= be_wstrb_i;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end
        if (aw_fire_c) begin
          aw_done_q <= 1'b1;
        end
        if (w_fire_c) begin
          w_done_q <= 1'b1;
        end
        if (b_fire_c && (axi_bresp_i != 2'b00)) begin
          err_q <= 1'b1;
        end
        if (r_fire_c) begin
          rdata_q  <= axi_rdata_i;
          rvalid_q <= 1'b1;
          if (axi_rresp_i != 2'b00) begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  // Outputs decode only registered state, so no valid depends on a ready.
  assign be_ready_o    = (state_q == IDLE);
  assign be_rdata_o    = rdata_q;
  assign be_rvalid_o   = rvalid_q;

  assign axi_awaddr_o  = addr_q;
  assign axi_awvalid_o = (state_q == WRITE) && !aw_done_q;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = wstrb_q;
  assign axi_wvalid_o  = (state_q == WRITE) && !w_done_q;
  assign axi_bready_o  = (state_q == WRESP);

  assign axi_araddr_o  = addr_q;
  assign axi_arvalid_o = (state_q == RADDR);
  assign axi_rready_o  = (state_q == RDATA);

  assign err_o         = err_q;

endmodule

// File: doc/iob_cache_axil_bridge.md
IOB_CACHE_AXIL_BRIDGE -- requirements
Module: iob_cache_axil_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 24: back-end byte-address width (cache BE_ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 32: back-end data width (cache BE_DATA_W), multiple of 8.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port `clk_i`, input, 1 bit: clock.
REQ-005 SHALL have port `cke_i`, input, 1 bit: clock enable.
REQ-006 SHALL have port `arst_i`, input, 1 bit: reset, synchronous active-high and sampled only on the rising edge of `clk_i`.
REQ-007 SHALL have port `be_valid_i`, input, 1 bit: native request valid from the cache back end.
REQ-008 SHALL have port `be_addr_i`, input, ADDR_W bits: request byte address.
REQ-009 SHALL have port `be_wdata_i`, input, DATA_W bits: write data.
REQ-010 SHALL have port `be_wstrb_i`, input, DATA_W/8 bits: write strobes; all zero means read.
REQ-011 SHALL have port `be_ready_o`, output, 1 bit: request accepted.
REQ-012 SHALL have port `be_rdata_o`, output, DATA_W bits: read data.
REQ-013 SHALL have port `be_rvalid_o`, output, 1 bit: read data valid, one-cycle pulse.
REQ-014 SHALL have these AXI4-Lite write ports: `axi_awaddr_o` (out, ADDR_W), `axi_awvalid_o` (out, 1), `axi_awready_i` (in, 1).
REQ-015 SHALL have these AXI4-Lite write-data ports: `axi_wdata_o` (out, DATA_W), `axi_wstrb_o` (out, DATA_W/8), `axi_wvalid_o` (out, 1), `axi_wready_i` (in, 1).
REQ-016 SHALL have these write-response ports: `axi_bresp_i` (in, 2), `axi_bvalid_i` (in, 1), `axi_bready_o` (out, 1).
REQ-017 SHALL have these read ports: `axi_araddr_o` (out, ADDR_W), `axi_arvalid_o` (out, 1), `axi_arready_i` (in, 1), `axi_rdata_i` (in, DATA_W), `axi_rresp_i` (in, 2), `axi_rvalid_i` (in, 1), `axi_rready_o` (out, 1).
REQ-018 SHALL have port `err_o`, output, 1 bit: sticky flag, set when a response is not OKAY.

Function
REQ-019 SHALL implement an FSM with states IDLE, WRITE, WRESP, RADDR, RDATA; state is held when `cke_i`=0, except that reset overrides `cke_i`.
REQ-020 SHALL drive `be_ready_o` = (state==IDLE) combinationally; a request is accepted when `be_valid_i` and `be_ready_o` are both high.
REQ-021 On acceptance SHALL register addr, wdata and wstrb, then go to WRITE if wstrb!=0, else to RADDR.
REQ-022 In WRITE SHALL assert `axi_awvalid_o` and `axi_wvalid_o` together, with `axi_awaddr_o` = registered addr and `axi_wdata_o`/`axi_wstrb_o` = registered data and strobes.
REQ-023 In WRITE SHALL deassert each of AW and W independently after its own handshake, and move to WRESP once both have completed; same-cycle handshakes move to WRESP immediately.
REQ-024 In WRESP SHALL assert `axi_bready_o`=1, and on `axi_bvalid_i` return to IDLE.
REQ-025 No `be_rvalid_o` SHALL be generated for writes.
REQ-026 In RADDR SHALL assert `axi_arvalid_o` with the registered addr, and on `axi_arready_i` go to RDATA.
REQ-027 In RDATA SHALL assert `axi_rready_o`=1; on `axi_rvalid_i` it SHALL register `axi_rdata_i` into `be_rdata_o`, pulse `be_rvalid_o` for exactly one cycle (the next cycle), and return to IDLE.
REQ-028 AXI valid outputs SHALL never depend combinationally on AXI ready inputs, and SHALL stay asserted with stable payload until their handshake completes.
REQ-029 `err_o` SHALL be set on `axi_bvalid_i` with `axi_bresp_i`!=0, or on `axi_rvalid_i` with `axi_rresp_i`!=0, and is cleared only by reset.
REQ-030 Read data SHALL be passed to `be_rdata_o` unchanged regardless of `axi_rresp_i`.
REQ-031 `be_rdata_o` SHALL hold its last value until the next read completes.
REQ-032 A request asserted while not in IDLE SHALL be ignored until IDLE is reached; there is exactly one outstanding transaction.
REQ-033 Minimum latency with AXI ready held high: write, acceptance at cycle N -> AW/W at N+1 -> B at N+2 earliest -> `be_ready_o` at N+3.
REQ-034 Minimum latency with AXI ready held high: read, acceptance at cycle N -> AR at N+1 -> R at N+2 -> `be_rvalid_o` at N+3, with `be_ready_o` high at N+3.

Reset
REQ-035 On `arst_i`=1 at a clock edge SHALL set state=IDLE and clear all AXI valid/ready outputs, `be_rvalid_o`, `be_rdata_o` and `err_o`; `be_ready_o` is then 1.
REQ-036 Reset mid-transaction SHALL abandon the transaction without completing it.

Verification
REQ-037 Read: addr=0x000104, AXI ready=1, rdata=0xDEADBEEF one cycle after AR -> `be_rvalid_o` pulses once at N+3 with 0xDEADBEEF, and `err_o`=0.
REQ-038 Write: addr=0x000020, wdata=0x12345678, wstrb=0xF, awready delayed 3 cycles, wready immediate -> `axi_wvalid_o` drops after 1 cycle, `axi_awvalid_o` is held 4 cycles, `axi_bready_o` follows, and `be_rvalid_o` stays 0.
REQ-039 Back-pressure: `be_valid_i` held high across 2 back-to-back reads -> exactly 2 AR handshakes, and `be_ready_o` is low outside IDLE.
REQ-040 Error: `axi_rresp_i`=2'b10 on a read -> data is delivered and `err_o`=1 and stays 1 until reset.
REQ-041 Reset asserted in WRESP -> next cycle all valids are 0 and `be_ready_o`=1; `cke_i`=0 for 5 cycles in RADDR -> `axi_arvalid_o` is held and state does not change.
